// File: rtl/btn_debounce_conditioner_if.sv
// Button conditioner bus: raw button inputs in, with clean levels, edge strobes
// and the running press count out.
interface btn_debounce_conditioner_if #(
  parameter int N_BTN = 8
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic             any_press;
  logic [7:0]       press_count;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, any_press, press_count
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, any_press, press_count
  );
endinterface

// File: rtl/btn_debounce_conditioner.sv
// Per-button 2-flop synchroniser plus debounce FSM; a level change is accepted only
// after DEBOUNCE_CYCLES consecutive stable synced samples. All outputs are registered.
module btn_debounce_conditioner #(
  parameter int N_BTN           = 8,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  btn_debounce_conditioner_if.slave   bus
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CONFIRM_HIGH,
    STABLE_HIGH,
    CONFIRM_LOW
  } db_state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state [N_BTN];
  logic [CNT_W-1:0] cnt   [N_BTN];

  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;
  logic [N_BTN-1:0] rise_acc;
  logic [N_BTN-1:0] fall_acc;
  logic [N_BTN-1:0] level_q;
  logic [N_BTN-1:0] press_q;
  logic [N_BTN-1:0] release_q;
  logic             any_q;
  logic [7:0]       count_q;

  function automatic logic [7:0] popcount(input logic [N_BTN-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < N_BTN; i++) begin
      n = n + 8'(v[i]);
    end
    return n;
  endfunction

  // Accept decision: the final confirming sample arrives while the count sits at its last value.
  always_comb begin
    rise_acc = '0;
    fall_acc = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rise_acc[i] = (state[i] == CONFIRM_HIGH) && sync_p1[i] && (cnt[i] == CNT_LAST);
      fall_acc[i] = (state[i] == CONFIRM_LOW) && !sync_p1[i] && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0   <= '0;
      sync_p1   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= STABLE_LOW;
        cnt[i]   <= '0;
      end
    end else begin
      // p0 -> p1: synchroniser; FSM below only ever looks at sync_p1
      sync_p0   <= bus.btn_raw;
      sync_p1   <= sync_p0;
      level_q   <= (level_q | rise_acc) & ~fall_acc;
      press_q   <= rise_acc;
      release_q <= fall_acc;
      any_q     <= |rise_acc;
      count_q   <= count_q + popcount(rise_acc);
      for (int i = 0; i < N_BTN; i++) begin
        case (state[i])
          STABLE_LOW: begin
            if (sync_p1[i]) begin
              state[i] <= CONFIRM_HIGH;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i]   <= '0;
            end
          end
          CONFIRM_HIGH: begin
            if (!sync_p1[i]) begin
              state[i] <= STABLE_LOW;
              cnt[i]   <= '0;
            end else if (rise_acc[i]) begin
              state[i] <= STABLE_HIGH;
              cnt[i]   <= '0;
            end else begin
              cnt[i]   <= cnt[i] + CNT_W'(1);
            end
          end
          STABLE_HIGH: begin
            if (!sync_p1[i]) begin
              state[i] <= CONFIRM_LOW;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i]   <= '0;
            end
          end
          CONFIRM_LOW: begin
            if (sync_p1[i]) begin
              state[i] <= STABLE_HIGH;
              cnt[i]   <= '0;
            end else if (fall_acc[i]) begin
              state[i] <= STABLE_LOW;
              cnt[i]   <= '0;
            end else begin
              cnt[i]   <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= STABLE_LOW;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.any_press   = any_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_btn_debounce_conditioner.sv
// Bench for btn_debounce_conditioner: directed vector table, randomized run against a
// sample-history reference model, and a 256-press counter wrap sequence.
module tb_btn_debounce_conditioner;
  localparam int N_BTN = 8;
  localparam int DB    = 4;
  localparam int CNT_W = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  btn_debounce_conditioner_if #(.N_BTN(N_BTN)) bus ();

  btn_debounce_conditioner #(
    .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic       rst;
    logic [7:0] raw;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rel;
    logic       any;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model: raw value seen at each edge, newest first; index k is k edges ago.
  logic [N_BTN-1:0] hist [0:DB+1];
  logic [N_BTN-1:0] m_level, m_press, m_release;
  logic             m_any;
  logic [7:0]       m_count;

  task automatic model_reset();
    for (int k = 0; k <= DB + 1; k++) hist[k] = '0;
    m_level = '0; m_press = '0; m_release = '0; m_any = 1'b0; m_count = '0;
  endtask

  // A change is accepted when the last DB synchronised samples (raw delayed by two edges)
  // all agree with each other and disagree with the current clean level.
  task automatic model_edge(input logic r, input logic [N_BTN-1:0] raw);
    bit all_one, all_zero;
    if (r) begin
      model_reset();
    end else begin
      for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = raw;
      m_press = '0;
      m_release = '0;
      for (int i = 0; i < N_BTN; i++) begin
        all_one = 1'b1;
        all_zero = 1'b1;
        for (int j = 2; j <= DB + 1; j++) begin
          if (hist[j][i]) all_zero = 1'b0;
          else            all_one  = 1'b0;
        end
        if (!m_level[i] && all_one)  m_press[i]   = 1'b1;
        if (m_level[i]  && all_zero) m_release[i] = 1'b1;
      end
      m_level = (m_level | m_press) & ~m_release;
      m_any   = |m_press;
      m_count = m_count + 8'($countones(m_press));
    end
  endtask

  task automatic step(input logic r, input logic [7:0] raw);
    rst = r;
    bus.btn_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
  endtask

  function automatic logic [32:0] dut_out();
    return {bus.btn_level, bus.btn_press, bus.btn_release, bus.any_press, bus.press_count};
  endfunction

  task automatic check(input string nm, input int idx, input logic [32:0] got, input logic [32:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl=%h prs=%h rel=%h any=%b cnt=%0d, expected lvl=%h prs=%h rel=%h any=%b cnt=%0d",
               nm, idx, got[32:25], got[24:17], got[16:9], got[8], got[7:0],
               exp[32:25], exp[24:17], exp[16:9], exp[8], exp[7:0]);
    end
  endtask

  task automatic add(input logic r, input logic [7:0] raw, input logic [7:0] lvl,
                     input logic [7:0] prs, input logic [7:0] rel, input logic any,
                     input logic [7:0] cnt, input int reps);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = lvl; v.prs = prs; v.rel = rel; v.any = any; v.cnt = cnt;
    for (int k = 0; k < reps; k++) tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] raw;
    logic [32:0] exp;
    rst = 1'b1;
    bus.btn_raw = 8'hFF;
    model_reset();

    //    rst raw    lvl    prs    rel    any cnt reps
    add(1, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 2);  // reset with all buttons pressed
    add(0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 5);  // btn0 rises before edge 0
    add(0, 8'h01, 8'h01, 8'h01, 8'h00, 1, 1, 1);  // accepted at edge 5
    add(0, 8'h01, 8'h01, 8'h00, 8'h00, 0, 1, 1);
    add(0, 8'h09, 8'h01, 8'h00, 8'h00, 0, 1, 3);  // btn3 short pulse: rejected
    add(0, 8'h01, 8'h01, 8'h00, 8'h00, 0, 1, 4);
    add(0, 8'h43, 8'h01, 8'h00, 8'h00, 0, 1, 5);  // btn1 + btn6 together
    add(0, 8'h43, 8'h43, 8'h42, 8'h00, 1, 3, 1);
    add(0, 8'h43, 8'h43, 8'h00, 8'h00, 0, 3, 1);
    add(0, 8'h42, 8'h43, 8'h00, 8'h00, 0, 3, 5);  // btn0 released
    add(0, 8'h42, 8'h42, 8'h00, 8'h01, 0, 3, 1);
    add(0, 8'h42, 8'h42, 8'h00, 8'h00, 0, 3, 1);
    add(0, 8'h4A, 8'h42, 8'h00, 8'h00, 0, 3, 1);  // btn3 bounce 1,0,1,1,...
    add(0, 8'h42, 8'h42, 8'h00, 8'h00, 0, 3, 1);
    add(0, 8'h4A, 8'h42, 8'h00, 8'h00, 0, 3, 5);
    add(0, 8'h4A, 8'h4A, 8'h08, 8'h00, 1, 4, 1);
    add(0, 8'h4A, 8'h4A, 8'h00, 8'h00, 0, 4, 1);
    add(1, 8'h4A, 8'h00, 8'h00, 8'h00, 0, 0, 1);  // reset clears everything
    add(0, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 4);  // btn2 into confirm
    add(1, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 1);  // reset mid-confirm
    add(0, 8'h04, 8'h00, 8'h00, 8'h00, 0, 0, 5);  // held through reset: fresh debounce
    add(0, 8'h04, 8'h04, 8'h04, 8'h00, 1, 1, 1);
    add(0, 8'h04, 8'h04, 8'h00, 8'h00, 0, 1, 1);

    foreach (tbl[k]) begin
      step(tbl[k].rst, tbl[k].raw);
      check("table", k, dut_out(),
            {tbl[k].lvl, tbl[k].prs, tbl[k].rel, tbl[k].any, tbl[k].cnt});
    end

    // Randomized: each bit toggles with probability 1/5 per cycle, rare reset pulses.
    step(1'b1, 8'h00);
    raw = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_BTN; i++) begin
        if ($urandom_range(4) == 0) raw[i] = ~raw[i];
      end
      step(($urandom_range(399) == 0), raw);
      exp = {m_level, m_press, m_release, m_any, m_count};
      check("random", c, dut_out(), exp);
    end

    // 256 clean presses on btn2: counter must wrap back to zero.
    step(1'b1, 8'h00);
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 12; k++) begin
        step(1'b0, (k < 6) ? 8'h04 : 8'h00);
        exp = {m_level, m_press, m_release, m_any, m_count};
        check("wrap_cycle", p, dut_out(), exp);
      end
      n_vec++;
      if (bus.press_count !== 8'(p + 1)) begin
        n_bad++;
        $display("FAIL wrap_count[%0d]: got %0d, expected %0d", p, bus.press_count, 8'(p + 1));
      end
    end
    n_vec++;
    if (bus.press_count !== 8'd0) begin
      n_bad++;
      $display("FAIL wrap_final: got %0d, expected 0", bus.press_count);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
